// File: rtl/id_ex_stage_reg_if.sv
// ID->EX stage bus: the ID-side handshake with its decoded fields, and the
// EX-side handshake with the packed word and the hazard-unit taps.
//  slave  : the stage register (takes the ID fields and out_ready; drives in_ready and the EX side)
//  master : the surrounding pipeline (drives the ID fields and out_ready)
interface id_ex_stage_reg_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned IMM_W  = 3
);
  localparam int unsigned PKT_W = 2 + DATA_W + REG_AW + IMM_W;

  logic              in_valid;
  logic              in_ready;
  logic              reg_write;
  logic              alu_instr;
  logic [DATA_W-1:0] data;
  logic [REG_AW-1:0] rd;
  logic [IMM_W-1:0]  immd;

  logic              out_valid;
  logic              out_ready;
  logic [PKT_W-1:0]  out;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_wr_pending;

  modport slave (
    input  in_valid, reg_write, alu_instr, data, rd, immd, out_ready,
    output in_ready, out_valid, out, ex_rd, ex_wr_pending
  );

  modport master (
    output in_valid, reg_write, alu_instr, data, rd, immd, out_ready,
    input  in_ready, out_valid, out, ex_rd, ex_wr_pending
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline stage register with a 2-entry skid buffer.
// Packs {reg_write, alu_instr, data, rd, immd} into one word; in_ready comes
// straight from the occupancy state, so there is no combinational path from
// out_ready. Supports a synchronous flush and a saturating stall counter.
//  clk, reset (sync, active-low), flush : control
//  bus (slave)  : ID handshake + fields in, EX handshake + packed word out,
//                 ex_rd / ex_wr_pending for the hazard unit
//  stall_cnt    : cycles with out_valid & !out_ready, saturating
module id_ex_stage_reg #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned IMM_W  = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  id_ex_stage_reg_if.slave       bus,
  output logic [CNT_W-1:0]       stall_cnt
);
  localparam int unsigned PKT_W = 2 + DATA_W + REG_AW + IMM_W;

  // One state per occupancy: main_v = (state != EMPTY), skid_v = (state == FULL)
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [PKT_W-1:0] main_q, main_d;
  logic [PKT_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic             main_v;
  logic             skid_v;
  logic             in_xfer;
  logic             out_xfer;
  logic [PKT_W-1:0] pkt;

  assign main_v   = (state_q != EMPTY);
  assign skid_v   = (state_q == FULL);
  assign pkt      = {bus.reg_write, bus.alu_instr, bus.data, bus.rd, bus.immd};
  assign in_xfer  = bus.in_valid & ~skid_v;
  assign out_xfer = main_v & bus.out_ready;

  // main_q is zeroed whenever it is vacated, so a bubble is an all-zero word
  assign bus.in_ready      = ~skid_v;
  assign bus.out_valid     = main_v;
  assign bus.out           = main_q;
  assign bus.ex_rd         = main_q[IMM_W +: REG_AW];
  assign bus.ex_wr_pending = main_v & main_q[PKT_W-1];
  assign stall_cnt         = stall_q;

  // Occupancy / payload next-state
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Squash both entries; a beat offered this cycle is dropped too
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = pkt;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = pkt;
          end else if (in_xfer) begin
            skid_d  = pkt;
            state_d = FULL;
          end else if (out_xfer) begin
            main_d  = '0;
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // Saturating stall counter; flush does not clear it
  always_comb begin
    stall_d = stall_q;
    if (main_v && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: a vector table for streaming,
// backpressure and flush, plus hand sequences for reset, counter
// saturation (a second instance with CNT_W=4) and reset while full.
module tb_id_ex_stage_reg;
  logic clk;
  logic reset;
  logic flush;
  logic [15:0] stall_cnt;
  logic [3:0]  sat_stall;

  int n_checks = 0;
  int n_errors = 0;

  id_ex_stage_reg_if #(.DATA_W(8), .REG_AW(3), .IMM_W(3)) bus ();
  id_ex_stage_reg_if #(.DATA_W(8), .REG_AW(3), .IMM_W(3)) sat_bus ();

  id_ex_stage_reg #(.DATA_W(8), .REG_AW(3), .IMM_W(3), .CNT_W(16)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  id_ex_stage_reg #(.DATA_W(8), .REG_AW(3), .IMM_W(3), .CNT_W(4)) u_sat (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (sat_bus),
    .stall_cnt (sat_stall)
  );

  // Saturation instance sees exactly the same stimulus
  assign sat_bus.in_valid  = bus.in_valid;
  assign sat_bus.reg_write = bus.reg_write;
  assign sat_bus.alu_instr = bus.alu_instr;
  assign sat_bus.data      = bus.data;
  assign sat_bus.rd        = bus.rd;
  assign sat_bus.immd      = bus.immd;
  assign sat_bus.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        fl;
    logic        iv;
    logic        rw;
    logic        alu;
    logic [7:0]  data;
    logic [2:0]  rd;
    logic [2:0]  immd;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic [15:0] e_out;
    logic [2:0]  e_rd;
    logic        e_wp;
    logic [15:0] e_stall;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic rw, input logic alu,
                       input logic [7:0] d, input logic [2:0] r, input logic [2:0] im,
                       input logic ordy);
    flush         = fl;
    bus.in_valid  = iv;
    bus.reg_write = rw;
    bus.alu_instr = alu;
    bus.data      = d;
    bus.rd        = r;
    bus.immd      = im;
    bus.out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Packets: A = {1,0,A5,5,2} -> A96A  B = {0,1,3C,1,7} -> 4F0F
    //          C = {1,1,FF,7,0} -> FFF8  D = {0,0,01,2,3} -> 0053
    //            fl    iv    rw    alu   data   rd    imm   ordy  ov    ir    out       rd    wp    stall
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 3'd5, 3'd2, 1'b1, 1'b1, 1'b1, 16'hA96A, 3'd5, 1'b1, 16'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 3'd1, 3'd7, 1'b1, 1'b1, 1'b1, 16'h4F0F, 3'd1, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 3'd7, 3'd0, 1'b1, 1'b1, 1'b1, 16'hFFF8, 3'd7, 1'b1, 16'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 16'h0000, 3'd0, 1'b0, 16'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 3'd5, 3'd2, 1'b0, 1'b1, 1'b1, 16'hA96A, 3'd5, 1'b1, 16'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 3'd1, 3'd7, 1'b0, 1'b1, 1'b0, 16'hA96A, 3'd5, 1'b1, 16'd1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 3'd7, 3'd0, 1'b0, 1'b1, 1'b0, 16'hA96A, 3'd5, 1'b1, 16'd2};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 3'd7, 3'd0, 1'b0, 1'b1, 1'b0, 16'hA96A, 3'd5, 1'b1, 16'd3};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 3'd7, 3'd0, 1'b1, 1'b1, 1'b1, 16'h4F0F, 3'd1, 1'b0, 16'd3};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 16'h0000, 3'd0, 1'b0, 16'd3};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 3'd2, 3'd3, 1'b1, 1'b1, 1'b1, 16'h0053, 3'd2, 1'b0, 16'd3};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 3'd7, 3'd0, 1'b0, 1'b1, 1'b0, 16'h0053, 3'd2, 1'b0, 16'd4};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 3'd5, 3'd2, 1'b0, 1'b0, 1'b1, 16'h0000, 3'd0, 1'b0, 16'd5};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 3'd0, 1'b0, 16'd5};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 3'd1, 3'd7, 1'b1, 1'b1, 1'b1, 16'h4F0F, 3'd1, 1'b0, 16'd5};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 3'd7, 3'd0, 1'b1, 1'b0, 1'b1, 16'h0000, 3'd0, 1'b0, 16'd5};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 16'h0000, 3'd0, 1'b0, 16'd5};

    // Reset held for two clocks with a beat offered
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 3'd5, 3'd2, 1'b0);
    step();
    step();
    check("rst_out", 32'(bus.out), 32'h0000);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_ex_wr_pending", 32'(bus.ex_wr_pending), 32'd0);
    check("rst_sat_stall", 32'(sat_stall), 32'd0);

    // Stream, backpressure and flush table
    reset = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].rw, vecs[i].alu,
            vecs[i].data, vecs[i].rd, vecs[i].immd, vecs[i].ordy);
      step();
      check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
      check($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_ir));
      check($sformatf("v%0d_out", i), 32'(bus.out), 32'(vecs[i].e_out));
      check($sformatf("v%0d_ex_rd", i), 32'(bus.ex_rd), 32'(vecs[i].e_rd));
      check($sformatf("v%0d_ex_wr_pending", i), 32'(bus.ex_wr_pending), 32'(vecs[i].e_wp));
      check($sformatf("v%0d_stall", i), 32'(stall_cnt), 32'(vecs[i].e_stall));
    end

    // Fill to FULL (A in main, B in skid) and hold out_ready low; counters start at 5
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 3'd5, 3'd2, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 3'd1, 3'd7, 1'b0);
    step();
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_stall", 32'(stall_cnt), 32'd6);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0);
    for (int i = 0; i < 9; i++) step();
    check("sat_reach_f", 32'(sat_stall), 32'hF);
    check("stall_mid", 32'(stall_cnt), 32'd15);
    for (int i = 0; i < 9; i++) step();
    check("sat_hold_f", 32'(sat_stall), 32'hF);
    check("stall_no_sat", 32'(stall_cnt), 32'd24);
    check("stall_out_held", 32'(bus.out), 32'hA96A);
    check("stall_ex_rd_held", 32'(bus.ex_rd), 32'd5);

    // Reset for one clock while FULL
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out", 32'(bus.out), 32'h0000);
    check("midrst_stall", 32'(stall_cnt), 32'd0);
    check("midrst_sat_stall", 32'(sat_stall), 32'd0);

    // Fresh beat after reset: latency 1, and skid content (B) must not reappear
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 3'd2, 3'd3, 1'b1);
    step();
    check("fresh_out_valid", 32'(bus.out_valid), 32'd1);
    check("fresh_out", 32'(bus.out), 32'h0053);
    check("fresh_ex_rd", 32'(bus.ex_rd), 32'd2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b1);
    step();
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);
    check("drain_out", 32'(bus.out), 32'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
